// File: rtl/mlsu_pkg.sv
// Shared types for the MLSU request sequencer: queued request entry and
// the per-side (load / store) in-flight state.
package mlsu_pkg;

    localparam int unsigned SeqIdWidth     = 5;
    localparam int unsigned SeqTxnCntWidth = 8;

    // One queued matrix request as held in the in-order buffer.
    typedef struct packed {
        logic [SeqIdWidth-1:0]     id;
        logic                      is_load;
        logic [SeqTxnCntWidth-1:0] ntxn;
    } seq_entry_t;

    // State of one dispatch side. DRAIN is only used by the store side for
    // zero-transaction stores, which complete without waiting for B beats.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } seq_side_e;

    // A side can take a new dispatch only when it is idle.
    function automatic logic side_idle(input seq_side_e s);
        return s == IDLE;
    endfunction

endpackage

// File: rtl/mlsu_seq_fifo.sv
// In-order request buffer: Depth-entry synchronous FIFO, no bypass.
// The head entry is presented combinationally from storage, so an entry
// written in cycle N becomes visible at the head in cycle N+1 at the earliest.
module mlsu_seq_fifo
    import mlsu_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = seq_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    entry_t        mem_q [Depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    // A full buffer refuses a write even if the head leaves in the same cycle.
    assign full_o  = (cnt_q == (AW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (Depth is a power of 2).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    // Entry storage; payload needs no reset since occupancy gates its use.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mlsu_req_sequencer.sv
// MLSU request sequencer: buffers load/store requests in order, offers the
// head to the load or store unit, tracks one load and one store in flight,
// counts AXI B beats for store completion and emits one-cycle response pulses.
module mlsu_req_sequencer
    import mlsu_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned IdWidth     = 5,
    parameter int unsigned TxnCntWidth = 8,
    parameter bit          Concurrent  = 1'b1,
    parameter bit          StrictOrder = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic                   req_is_load_i,
    input  logic [TxnCntWidth-1:0] req_ntxn_i,
    input  logic                   core_st_pending_i,
    output logic                   ld_valid_o,
    input  logic                   ld_ready_i,
    output logic [IdWidth-1:0]     ld_id_o,
    output logic                   st_valid_o,
    input  logic                   st_ready_i,
    output logic [IdWidth-1:0]     st_id_o,
    output logic [TxnCntWidth-1:0] st_ntxn_o,
    input  logic                   ld_done_i,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    output logic                   resp_ld_valid_o,
    output logic                   resp_st_valid_o,
    output logic [2*IdWidth-1:0]   resp_id_o,
    output logic                   err_o
);

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic                   is_load;
        logic [TxnCntWidth-1:0] ntxn;
    } entry_t;

    entry_t                 enq_entry;
    entry_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    seq_side_e              ld_side_q;
    seq_side_e              st_side_q;
    logic [IdWidth-1:0]     ld_id_q;
    logic [IdWidth-1:0]     st_id_q;
    logic [TxnCntWidth-1:0] st_ntxn_q;
    logic [TxnCntWidth-1:0] b_cnt_q;
    logic [TxnCntWidth-1:0] b_cnt_inc;
    logic                   resp_ld_q;
    logic                   resp_st_q;
    logic [IdWidth-1:0]     resp_ld_id_q;
    logic [IdWidth-1:0]     resp_st_id_q;
    logic                   err_q;

    logic                   ld_idle;
    logic                   st_idle;
    logic                   conc_ok;
    logic                   ld_fire;
    logic                   st_fire;

    assign enq_entry = '{id: req_id_i, is_load: req_is_load_i, ntxn: req_ntxn_i};

    mlsu_seq_fifo #(
        .Depth   (Depth),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_valid_i),
        .wdata_i (enq_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshakes (request, load dispatch, store dispatch): a transfer happens
    // in the cycle where valid && ready; valid, once raised for an entry, is
    // kept with its payload unchanged until ready. Only the buffer head is
    // ever offered, so a blocked head holds back every younger request.
    assign req_ready_o = !fifo_full;

    assign ld_idle = side_idle(ld_side_q);
    assign st_idle = side_idle(st_side_q);
    assign conc_ok = Concurrent || (ld_idle && st_idle);

    // A load also waits for scalar core stores and, in strict mode, for any
    // in-flight matrix store, so it cannot read stale data.
    assign ld_valid_o = !fifo_empty && head.is_load && ld_idle && !core_st_pending_i
                        && !(StrictOrder && !st_idle) && conc_ok;
    assign st_valid_o = !fifo_empty && !head.is_load && st_idle && conc_ok;

    assign ld_fire  = ld_valid_o && ld_ready_i;
    assign st_fire  = st_valid_o && st_ready_i;
    assign fifo_pop = ld_fire || st_fire;

    assign ld_id_o   = head.id;
    assign st_id_o   = head.id;
    assign st_ntxn_o = head.ntxn;
    assign b_ready_o = 1'b1;

    assign b_cnt_inc = b_cnt_q + TxnCntWidth'(1);

    assign resp_ld_valid_o = resp_ld_q;
    assign resp_st_valid_o = resp_st_q;
    assign resp_id_o       = {resp_st_id_q, resp_ld_id_q};
    assign err_o           = err_q;

    // Load/store side FSMs, B-beat counter, response pulses and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_side_q    <= IDLE;
            st_side_q    <= IDLE;
            ld_id_q      <= '0;
            st_id_q      <= '0;
            st_ntxn_q    <= '0;
            b_cnt_q      <= '0;
            resp_ld_q    <= 1'b0;
            resp_st_q    <= 1'b0;
            resp_ld_id_q <= '0;
            resp_st_id_q <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_ld_q <= 1'b0;
            resp_st_q <= 1'b0;

            case (ld_side_q)
                IDLE: begin
                    if (ld_fire) begin
                        ld_side_q <= BUSY;
                        ld_id_q   <= head.id;
                    end
                end
                BUSY: begin
                    if (ld_done_i) begin
                        ld_side_q    <= IDLE;
                        resp_ld_q    <= 1'b1;
                        resp_ld_id_q <= ld_id_q;
                    end
                end
                default: ld_side_q <= IDLE;
            endcase

            case (st_side_q)
                IDLE: begin
                    if (st_fire) begin
                        st_id_q   <= head.id;
                        st_ntxn_q <= head.ntxn;
                        b_cnt_q   <= '0;
                        if (head.ntxn == '0) begin
                            // Nothing to wait for: report completion right away.
                            st_side_q    <= DRAIN;
                            resp_st_q    <= 1'b1;
                            resp_st_id_q <= head.id;
                        end else begin
                            st_side_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (b_valid_i) begin
                        b_cnt_q <= b_cnt_inc;
                        if (b_cnt_inc == st_ntxn_q) begin
                            st_side_q    <= IDLE;
                            resp_st_q    <= 1'b1;
                            resp_st_id_q <= st_id_q;
                        end
                    end
                end
                DRAIN:   st_side_q <= IDLE;
                default: st_side_q <= IDLE;
            endcase

            // Completion events with nothing to complete are protocol errors.
            if ((ld_done_i && ld_side_q != BUSY) || (b_valid_i && st_side_q == IDLE)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
